// File: rtl/uart_word_bridge.sv
// Byte <-> word bridge between the UART rx/tx cores and the debug unit.
// RX packs little-endian bytes into words with an idle timeout; TX serializes words byte by byte.
module uart_word_bridge #(
    parameter int NBITS      = 32,
    parameter int BYTE_W     = 8,
    parameter int RX_TIMEOUT = 2**20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] uart_rx_byte,
    input  logic              uart_rx_valid,
    output logic [BYTE_W-1:0] uart_tx_byte,
    output logic              uart_tx_start,
    input  logic              uart_tx_done,
    output logic [NBITS-1:0]  rx_Data,
    output logic              rx_done,
    output logic              rx_timeout,
    input  logic              tx_start,
    input  logic [NBITS-1:0]  tx_Data,
    output logic              tx_done,
    output logic              tx_busy
);

    localparam int NBYTES = NBITS / BYTE_W;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int TO_W   = (RX_TIMEOUT > 1) ? $clog2(RX_TIMEOUT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = (RX_TIMEOUT > 0) ? TO_W'(RX_TIMEOUT - 1) : '0;
    localparam bit TIMEOUT_EN = (RX_TIMEOUT > 0);

    // Words are held as byte lanes so byte N is simply lane N (little-endian).
    typedef logic [NBYTES-1:0][BYTE_W-1:0] word_t;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_SEND = 2'd1,
        TX_WAIT = 2'd2
    } tx_state_t;

    // ------------------------------------------------------------------
    // RX path
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] rx_idx_q, rx_idx_d;
    word_t            rx_asm_q, rx_asm_d;
    word_t            rx_data_q, rx_data_d;
    logic             rx_done_q, rx_done_d;
    logic             rx_timeout_q, rx_timeout_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             to_hit;

    assign to_hit = TIMEOUT_EN && (to_cnt_q == TO_LAST);

    always_comb begin
        rx_idx_d     = rx_idx_q;
        rx_asm_d     = rx_asm_q;
        rx_data_d    = rx_data_q;
        rx_done_d    = 1'b0;
        rx_timeout_d = 1'b0;
        to_cnt_d     = to_cnt_q;

        if (uart_rx_valid) begin
            // A byte in the expiry cycle takes priority over the timeout.
            rx_asm_d[rx_idx_q] = uart_rx_byte;
            to_cnt_d           = '0;
            if (rx_idx_q == LAST_IDX) begin
                rx_data_d = rx_asm_d;
                rx_done_d = 1'b1;
                rx_idx_d  = '0;
                rx_asm_d  = '0;
            end else begin
                rx_idx_d = rx_idx_q + IDX_W'(1);
            end
        end else if (rx_idx_q != '0) begin
            if (to_hit) begin
                rx_idx_d     = '0;
                rx_asm_d     = '0;
                to_cnt_d     = '0;
                rx_timeout_d = 1'b1;
            end else if (TIMEOUT_EN) begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_idx_q     <= '0;
            rx_asm_q     <= '0;
            rx_data_q    <= '0;
            rx_done_q    <= 1'b0;
            rx_timeout_q <= 1'b0;
            to_cnt_q     <= '0;
        end else begin
            rx_idx_q     <= rx_idx_d;
            rx_asm_q     <= rx_asm_d;
            rx_data_q    <= rx_data_d;
            rx_done_q    <= rx_done_d;
            rx_timeout_q <= rx_timeout_d;
            to_cnt_q     <= to_cnt_d;
        end
    end

    assign rx_Data    = rx_data_q;
    assign rx_done    = rx_done_q;
    assign rx_timeout = rx_timeout_q;

    // ------------------------------------------------------------------
    // TX path
    // ------------------------------------------------------------------
    tx_state_t         tx_state_q, tx_state_d;
    word_t             tx_buf_q, tx_buf_d;
    logic [IDX_W-1:0]  tx_idx_q, tx_idx_d;
    logic [BYTE_W-1:0] uart_byte_q, uart_byte_d;
    logic              uart_start_q, uart_start_d;
    logic              tx_done_q, tx_done_d;
    logic              tx_busy_q, tx_busy_d;
    logic [IDX_W-1:0]  tx_idx_inc;

    assign tx_idx_inc = tx_idx_q + IDX_W'(1);

    always_comb begin
        tx_state_d   = tx_state_q;
        tx_buf_d     = tx_buf_q;
        tx_idx_d     = tx_idx_q;
        uart_byte_d  = uart_byte_q;
        uart_start_d = 1'b0;
        tx_done_d    = 1'b0;
        tx_busy_d    = tx_busy_q;

        // The outgoing byte is registered on entry to TX_SEND so it is
        // valid with the start strobe and holds until the next byte.
        case (tx_state_q)
            TX_IDLE: begin
                if (tx_start) begin
                    tx_buf_d     = tx_Data;
                    tx_idx_d     = '0;
                    tx_busy_d    = 1'b1;
                    uart_byte_d  = tx_Data[BYTE_W-1:0];
                    uart_start_d = 1'b1;
                    tx_state_d   = TX_SEND;
                end
            end
            TX_SEND: begin
                tx_state_d = TX_WAIT;
            end
            TX_WAIT: begin
                if (uart_tx_done) begin
                    if (tx_idx_q == LAST_IDX) begin
                        tx_done_d  = 1'b1;
                        tx_busy_d  = 1'b0;
                        tx_state_d = TX_IDLE;
                    end else begin
                        tx_idx_d     = tx_idx_inc;
                        uart_byte_d  = tx_buf_q[tx_idx_inc];
                        uart_start_d = 1'b1;
                        tx_state_d   = TX_SEND;
                    end
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q   <= TX_IDLE;
            tx_buf_q     <= '0;
            tx_idx_q     <= '0;
            uart_byte_q  <= '0;
            uart_start_q <= 1'b0;
            tx_done_q    <= 1'b0;
            tx_busy_q    <= 1'b0;
        end else begin
            tx_state_q   <= tx_state_d;
            tx_buf_q     <= tx_buf_d;
            tx_idx_q     <= tx_idx_d;
            uart_byte_q  <= uart_byte_d;
            uart_start_q <= uart_start_d;
            tx_done_q    <= tx_done_d;
            tx_busy_q    <= tx_busy_d;
        end
    end

    assign uart_tx_byte  = uart_byte_q;
    assign uart_tx_start = uart_start_q;
    assign tx_done       = tx_done_q;
    assign tx_busy       = tx_busy_q;

endmodule

// File: tb/tb_uart_word_bridge.sv
// Randomized bench for uart_word_bridge: a queue-based reference model predicts every output
// each cycle, plus directed scenarios for ordering, timeout, ignored starts, reset and full duplex.
module tb_uart_word_bridge;

    localparam int NBITS  = 32;
    localparam int BYTE_W = 8;
    localparam int NBYTES = NBITS / BYTE_W;
    localparam int RX_TO  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [BYTE_W-1:0] uart_rx_byte = '0;
    logic              uart_rx_valid = 1'b0;
    logic [BYTE_W-1:0] uart_tx_byte;
    logic              uart_tx_start;
    logic              uart_tx_done = 1'b0;
    logic [NBITS-1:0]  rx_Data;
    logic              rx_done;
    logic              rx_timeout;
    logic              tx_start = 1'b0;
    logic [NBITS-1:0]  tx_Data = '0;
    logic              tx_done;
    logic              tx_busy;

    always #5 clk = ~clk;

    uart_word_bridge #(
        .NBITS(NBITS),
        .BYTE_W(BYTE_W),
        .RX_TIMEOUT(RX_TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .uart_rx_byte(uart_rx_byte),
        .uart_rx_valid(uart_rx_valid),
        .uart_tx_byte(uart_tx_byte),
        .uart_tx_start(uart_tx_start),
        .uart_tx_done(uart_tx_done),
        .rx_Data(rx_Data),
        .rx_done(rx_done),
        .rx_timeout(rx_timeout),
        .tx_start(tx_start),
        .tx_Data(tx_Data),
        .tx_done(tx_done),
        .tx_busy(tx_busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit [7:0]  rxq[$];
    bit [7:0]  txq[$];
    bit [31:0] m_rx_data;
    bit        m_rx_done, m_rx_to;
    longint    cyc, last_valid;
    bit        m_busy, m_send, m_wait, m_ustart, m_tx_done;
    bit [7:0]  m_ubyte;

    task automatic model_reset();
        rxq.delete();
        txq.delete();
        m_rx_data = '0;
        m_rx_done = 0;
        m_rx_to   = 0;
        m_busy    = 0;
        m_send    = 0;
        m_wait    = 0;
        m_ustart  = 0;
        m_tx_done = 0;
        m_ubyte   = '0;
    endtask

    task automatic model_step();
        bit was_wait;
        cyc++;
        m_rx_done = 0;
        m_rx_to   = 0;
        if (uart_rx_valid) begin
            rxq.push_back(uart_rx_byte);
            last_valid = cyc;
            if (rxq.size() == NBYTES) begin
                for (int i = 0; i < NBYTES; i++) m_rx_data[8*i +: 8] = rxq[i];
                m_rx_done = 1;
                rxq.delete();
            end
        end else if (rxq.size() != 0 && (cyc - last_valid) == RX_TO) begin
            rxq.delete();
            m_rx_to = 1;
        end

        was_wait  = m_wait;
        m_ustart  = 0;
        m_tx_done = 0;
        if (m_send) begin
            m_send = 0;
            m_wait = 1;
        end
        if (!m_busy) begin
            if (tx_start) begin
                for (int i = 0; i < NBYTES; i++) txq.push_back(tx_Data[8*i +: 8]);
                m_busy   = 1;
                m_ubyte  = txq.pop_front();
                m_ustart = 1;
                m_send   = 1;
            end
        end else if (was_wait && uart_tx_done) begin
            m_wait = 0;
            if (txq.size() == 0) begin
                m_busy    = 0;
                m_tx_done = 1;
            end else begin
                m_ubyte  = txq.pop_front();
                m_ustart = 1;
                m_send   = 1;
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    // ---------------- per-cycle compare and strobe counters ----------------
    int rx_done_cnt = 0, rx_to_cnt = 0, tx_done_cnt = 0;

    initial begin
        forever begin
            @(negedge clk);
            check("rx_done", rx_done, m_rx_done);
            check("rx_timeout", rx_timeout, m_rx_to);
            check("rx_Data", rx_Data, m_rx_data);
            check("uart_tx_start", uart_tx_start, m_ustart);
            check("uart_tx_byte", uart_tx_byte, m_ubyte);
            check("tx_done", tx_done, m_tx_done);
            check("tx_busy", tx_busy, m_busy);
            if (rx_done === 1'b1) rx_done_cnt++;
            if (rx_timeout === 1'b1) rx_to_cnt++;
            if (tx_done === 1'b1) tx_done_cnt++;
        end
    end

    // ---------------- UART transmitter responder ----------------
    bit       resp_rand = 0;
    bit [7:0] txlog[$];

    initial begin
        forever begin
            @(negedge clk);
            if (uart_tx_start === 1'b1) begin
                int d;
                $display("tx byte %02h", uart_tx_byte);
                txlog.push_back(uart_tx_byte);
                d = resp_rand ? int'($urandom_range(1, 12)) : 10;
                repeat (d) @(posedge clk);
                #1 uart_tx_done = 1'b1;
                @(posedge clk);
                #1 uart_tx_done = 1'b0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rx_byte(input logic [7:0] b);
        uart_rx_valid = 1'b1;
        uart_rx_byte  = b;
        tick(1);
        uart_rx_valid = 1'b0;
    endtask

    task automatic rx_word(input logic [31:0] w, input int maxgap);
        for (int i = 0; i < NBYTES; i++) begin
            rx_byte(w[8*i +: 8]);
            if (i < NBYTES - 1) tick($urandom_range(0, maxgap));
        end
        $display("rx word sent %08h, rx_Data=%08h", w, rx_Data);
    endtask

    task automatic tx_word(input logic [31:0] w);
        tx_start = 1'b1;
        tx_Data  = w;
        tick(1);
        tx_start = 1'b0;
        $display("tx_start %08h", w);
    endtask

    task automatic wait_tx_idle();
        int n = 0;
        while (m_busy && n < 2000) begin
            tick(1);
            n++;
        end
        check("tx_wait_bound", tx_busy, 1'b0);
    endtask

    task automatic check_txlog(input string tag, input logic [63:0] exp, input int nbytes);
        check({tag, "_count"}, txlog.size(), nbytes);
        for (int i = 0; i < nbytes && i < txlog.size(); i++)
            check(tag, txlog[i], exp[8*i +: 8]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int base_rx, base_to, base_tx;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_rx_Data", rx_Data, 0);
        check("rst_tx_busy", tx_busy, 0);
        check("rst_uart_tx_start", uart_tx_start, 0);
        rst = 1'b0;
        tick(2);

        // 1: little-endian packing with random gaps below the timeout
        base_rx = rx_done_cnt;
        rx_word(32'h12345678, 15);
        check("t1_rx_data", rx_Data, 32'h12345678);
        check("t1_rx_done_now", rx_done, 1'b1);
        tick(2);
        check("t1_rx_done_cnt", rx_done_cnt - base_rx, 1);

        // 2: serialization order and acknowledgement
        txlog.delete();
        base_tx = tx_done_cnt;
        tx_word(32'hDEADBEEF);
        check("t2_uart_start_latency", uart_tx_start, 1'b1);
        wait_tx_idle();
        tick(2);
        check_txlog("t2_bytes", 64'hDEADBEEF, 4);
        check("t2_tx_done_cnt", tx_done_cnt - base_tx, 1);

        // 3: timeout discards partial word, then boundary cases
        base_to = rx_to_cnt;
        rx_byte(8'hAA);
        tick(3);
        rx_byte(8'hBB);
        tick(20);
        check("t3_timeout_cnt", rx_to_cnt - base_to, 1);
        check("t3_rx_unchanged", rx_Data, 32'h12345678);
        rx_word(32'h04030201, 15);
        check("t3_rx_data", rx_Data, 32'h04030201);
        base_to = rx_to_cnt;
        rx_byte(8'hAB); tick(15);
        rx_byte(8'hCD); tick(15);
        rx_byte(8'hEF);
        rx_byte(8'h01);
        check("t3_byte_wins_data", rx_Data, 32'h01EFCDAB);
        check("t3_byte_wins_noto", rx_to_cnt - base_to, 0);
        rx_byte(8'h11); tick(16);
        rx_word(32'hA5A55A5A, 3);
        check("t3_gap16_data", rx_Data, 32'hA5A55A5A);
        check("t3_gap16_to", rx_to_cnt - base_to, 1);

        // 4: tx_start while busy is ignored
        txlog.delete();
        base_tx = tx_done_cnt;
        tx_word(32'hCAFEF00D);
        tick(12);
        tx_word(32'h11223344);
        wait_tx_idle();
        tick(2);
        check_txlog("t4_bytes", 64'hCAFEF00D, 4);
        check("t4_tx_done_cnt", tx_done_cnt - base_tx, 1);

        // 5: reset mid-word on both paths
        txlog.delete();
        fork
            tx_word(32'h55667788);
            begin rx_byte(8'hC1); tick(2); rx_byte(8'hC2); end
        join
        for (int n = 0; n < 200 && txlog.size() < 2; n++) tick(1);
        check("t5_two_bytes_sent", txlog.size(), 2);
        tick(3);
        base_rx = rx_done_cnt;
        base_tx = tx_done_cnt;
        #2 rst = 1'b1;
        #1;
        check("t5_rst_rx_Data", rx_Data, 0);
        check("t5_rst_tx_busy", tx_busy, 0);
        check("t5_rst_uart_tx_byte", uart_tx_byte, 0);
        check("t5_rst_uart_tx_start", uart_tx_start, 0);
        check("t5_rst_done", {rx_done, rx_timeout, tx_done}, 0);
        @(posedge clk);
        #1;
        tick(2);
        rst = 1'b0;
        tick(25);
        check("t5_no_rx_done", rx_done_cnt - base_rx, 0);
        check("t5_no_tx_done", tx_done_cnt - base_tx, 0);
        txlog.delete();
        rx_word(32'h87654321, 5);
        check("t5_rx_after", rx_Data, 32'h87654321);
        tx_word(32'h0F1E2D3C);
        wait_tx_idle();
        tick(2);
        check_txlog("t5_tx_after", 64'h0F1E2D3C, 4);

        // 6: full duplex, back-to-back tx_start in the tx_done cycle
        txlog.delete();
        fork
            begin
                rx_word(32'h0BADC0DE, 6);
                check("t6_rx_data", rx_Data, 32'h0BADC0DE);
            end
            begin
                int n;
                tx_word(32'h01234567);
                n = 0;
                while (tx_done !== 1'b1 && n < 500) begin
                    tick(1);
                    n++;
                end
                check("t6_done_seen", tx_done, 1'b1);
                tx_word(32'h89ABCDEF);
                check("t6_b2b_start", uart_tx_start, 1'b1);
                wait_tx_idle();
            end
        join
        tick(2);
        check_txlog("t6_bytes", 64'h89ABCDEF_01234567, 8);

        // random full-duplex traffic, including timeouts and ignored starts
        resp_rand = 1;
        fork
            repeat (60) begin
                rx_byte(8'($urandom));
                tick($urandom_range(0, 20));
            end
            repeat (10) begin
                tx_word($urandom);
                if ($urandom_range(0, 1) == 1) begin
                    tick($urandom_range(1, 8));
                    tx_word($urandom);
                end
                wait_tx_idle();
                tick($urandom_range(0, 3));
            end
        join
        tick(30);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
